mem_bus_responder: RTL
======================

Name: mem_bus_responder

Overview:
- External-side memory responder for the bus interface unit; it answers the bus cycles that unit initiates.
- Latches a 20-bit physical address on an address-latch strobe, inserts a programmable number of wait states, then either drives a byte onto the 8-bit data bus (read) or captures a byte from it (write).
- Completion is signalled with a one-cycle READY. Addresses outside the mapped window complete with BUS_ERR.

Parameters:
- ADDR_BITS, 8, log2 of the byte-storage depth (2^ADDR_BITS bytes).
- BASE, 20'h00000, first physical address mapped; window is [BASE, BASE + 2^ADDR_BITS - 1].
- WAIT_CYCLES, 2, wait states inserted per access; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ALE  input  1  address latch enable; 1-cycle pulse that starts a bus cycle.
- Address  input  20  physical address (segment*16 + offset), sampled when ALE=1.
- RD_WR  input  1  cycle type, sampled with ALE; 1 = read, 0 = write.
- Data  inout  8  external data bus; driven only in read ACCESS/ERR cycles, otherwise high-Z.
- READY  output  1  1-cycle completion strobe.
- BUS_ERR  output  1  high with READY when the latched address is outside the window.
- BUSY  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; READY=0, BUS_ERR=0, BUSY=0; Data=Z.
  - Wait counter=0; latched address and type=0.
  - Storage contents are not cleared.
- State IDLE:
  - ALE=1 latches Address and RD_WR at the rising edge.
  - Out-of-window address -> ERR.
  - In window with WAIT_CYCLES=0 -> ACCESS.
  - In window with WAIT_CYCLES>0 -> WAIT, counter loaded with WAIT_CYCLES.
- State WAIT: counter decrements each cycle. At counter=1, next state is ACCESS. READY=0, Data=Z.
- State ACCESS (exactly one cycle), READY=1:
  - Read: Data = mem[Address-BASE] for the whole cycle.
  - Write: mem[Address-BASE] <= Data at the rising edge ending the cycle.
  - Next state IDLE.
- State ERR (one cycle): READY=1, BUS_ERR=1.
  - Read: Data driven 8'hFF.
  - Write: storage not modified.
  - Next state IDLE.
- Latency: ALE sampled at edge k -> READY high during cycle k+WAIT_CYCLES+1. ERR completes at k+1 regardless of WAIT_CYCLES.
- Back-to-back access: ALE may be asserted in the cycle right after READY. Minimum spacing is WAIT_CYCLES+2 cycles per access.
- ALE while BUSY: ignored. The latched address and type are not overwritten, and no cycle is queued.
- Window math:
  - offset = Address - BASE, 20-bit unsigned.
  - In window iff Address >= BASE and offset < 2^ADDR_BITS.
  - No wrap-around: BASE + depth beyond 20'hFFFFF is clipped at 20'hFFFFF.
- Address changes after the ALE edge have no effect.
- Write data is sampled only at the ACCESS edge; values on Data during WAIT are ignored.
- Reset mid-cycle: the access is aborted and READY is never issued. A write aborted before its ACCESS edge leaves storage unchanged.
- Bus contention rule: the block never drives Data outside read ACCESS/ERR. The initiator must release Data for read cycles.

Test Plan:
1. Reset, write then read back (WAIT_CYCLES=2):
   - Stimulus: after reset, ALE with Address=20'h00010, RD_WR=0, Data=8'hA5.
   - Required: READY at k+3, BUSY high k+1..k+3.
   - Then read of 20'h00010: Data=8'hA5 with READY at k+3, and Data=Z otherwise.
2. Zero wait states (WAIT_CYCLES=0):
   - Stimulus: read 20'h000FF after writing 8'h3C.
   - Required: READY in cycle k+1, Data=8'h3C.
3. Out-of-window read (BASE=20'h00000, ADDR_BITS=8):
   - Stimulus: read 20'h00100.
   - Required: READY=1, BUS_ERR=1, Data=8'hFF at k+1.
   - Same address as a write: BUS_ERR=1, and mem[0] is unchanged.
4. ALE while busy:
   - Stimulus: ALE at k to 20'h00020, second ALE at k+1 to 20'h00030.
   - Required: exactly one READY at k+3, and it serves 20'h00020.
   - A read-back of 20'h00030 confirms it was untouched.
5. Reset mid-write:
   - Stimulus: write 8'h77 to 20'h00040 (previously 8'h11); drive rst=0 at k+2.
   - Required: READY never asserts, state IDLE, read of 20'h00040 returns 8'h11.
6. Back-to-back:
   - Stimulus: ALE re-asserted in the READY+1 cycle for 4 consecutive reads.
   - Required: READY pulses spaced exactly 4 cycles apart (WAIT_CYCLES=2) with correct data each time.

Source files
------------

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: byte memory answering latched-address bus cycles after
// programmable wait states, with BUS_ERR completion for unmapped addresses.
module mem_bus_responder #(
  parameter int          ADDR_BITS   = 8,
  parameter logic [19:0] BASE        = 20'h00000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ALE,
  input  logic [19:0] Address,
  input  logic        RD_WR,
  inout  wire  [7:0]  Data,
  output logic        READY,
  output logic        BUS_ERR,
  output logic        BUSY
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_ERR} state_t;
  localparam logic [20:0] DEPTH = 21'(1) << ADDR_BITS;
  state_t               r_state, w_nstate;
  logic [3:0]           r_cnt, w_ncnt;
  logic [19:0]          r_addr;
  logic                 r_rd;
  logic [7:0]           r_mem [2**ADDR_BITS];
  logic [19:0]          w_off;
  logic                 w_in;
  logic [ADDR_BITS-1:0] w_idx;
  logic [7:0]           w_dout;
  // window end is naturally clipped: Address never exceeds 20'hFFFFF
  assign w_off   = Address - BASE;
  assign w_in    = Address >= BASE && {1'b0, w_off} < DEPTH;
  assign w_idx   = ADDR_BITS'(r_addr - BASE);
  assign READY   = r_state == S_ACCESS || r_state == S_ERR;
  assign BUS_ERR = r_state == S_ERR;
  assign BUSY    = r_state != S_IDLE;
  assign w_dout  = BUS_ERR ? 8'hFF : r_mem[w_idx];
  assign Data    = READY && r_rd ? w_dout : 8'hzz;
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    case (r_state)
      S_IDLE: if (ALE) begin
        w_nstate = !w_in ? S_ERR : (WAIT_CYCLES == 0 ? S_ACCESS : S_WAIT);
        w_ncnt   = w_in ? 4'(WAIT_CYCLES) : 4'd0;
      end
      S_WAIT: begin
        w_ncnt   = r_cnt - 4'd1;
        w_nstate = r_cnt == 4'd1 ? S_ACCESS : S_WAIT;
      end
      default: w_nstate = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      if (r_state == S_IDLE && ALE) begin
        r_addr <= Address;
        r_rd   <= RD_WR;
      end
    end
  end
  // storage survives reset; a reset forces IDLE so no aborted write lands
  always_ff @(posedge clk)
    if (r_state == S_ACCESS && !r_rd) r_mem[w_idx] <= Data;
endmodule
